// File: rtl/result_arbiter.sv
// result_arbiter
// Round-robin arbiter that shares the MEM-stage writeback path among the
// MUL, DIV and FPU result producers. The single winning result each cycle
// is captured in a one-entry output register that feeds rd_*_MEM.

module result_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              valid_in_mul,
    input  logic              valid_in_div,
    input  logic              valid_in_fpu,
    output logic              ready_out_mul,
    output logic              ready_out_div,
    output logic              ready_out_fpu,

    input  logic [ADDR_W-1:0] rd_addr_mul,
    input  logic [ADDR_W-1:0] rd_addr_div,
    input  logic [ADDR_W-1:0] rd_addr_fpu,
    input  logic [DATA_W-1:0] rd_data_mul,
    input  logic [DATA_W-1:0] rd_data_div,
    input  logic [DATA_W-1:0] rd_data_fpu,
    input  logic [FLAG_W-1:0] flags_fpu,

    output logic              valid_out,
    input  logic              ready_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic [FLAG_W-1:0] flags_out,
    output logic [1:0]        src_out
);

    // Source identifiers; SRC_NONE marks "no requester granted".
    localparam logic [1:0] SRC_MUL  = 2'd0;
    localparam logic [1:0] SRC_DIV  = 2'd1;
    localparam logic [1:0] SRC_FPU  = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    // The pointer never legally holds 3; fold that value onto MUL so a
    // corrupted pointer still produces a sane scan order.
    function automatic logic [1:0] norm_prio(input logic [1:0] p);
        logic [1:0] r;
        case (p)
            2'd0:    r = 2'd0;
            2'd1:    r = 2'd1;
            2'd2:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Pointer value after source k wins: (k+1) mod 3.
    function automatic logic [1:0] next_prio(input logic [1:0] k);
        logic [1:0] r;
        case (k)
            SRC_MUL: r = SRC_DIV;
            SRC_DIV: r = SRC_FPU;
            SRC_FPU: r = SRC_MUL;
            default: r = SRC_MUL;
        endcase
        return r;
    endfunction

    // Return the first requester found scanning p, p+1, p+2 (mod 3),
    // or SRC_NONE when no bit of req is set. req bit order: {fpu, div, mul}.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] p);
        logic [1:0] r;
        case (p)
            2'd1: begin
                if (req[1]) begin
                    r = SRC_DIV;
                end else if (req[2]) begin
                    r = SRC_FPU;
                end else if (req[0]) begin
                    r = SRC_MUL;
                end else begin
                    r = SRC_NONE;
                end
            end
            2'd2: begin
                if (req[2]) begin
                    r = SRC_FPU;
                end else if (req[0]) begin
                    r = SRC_MUL;
                end else if (req[1]) begin
                    r = SRC_DIV;
                end else begin
                    r = SRC_NONE;
                end
            end
            default: begin
                if (req[0]) begin
                    r = SRC_MUL;
                end else if (req[1]) begin
                    r = SRC_DIV;
                end else if (req[2]) begin
                    r = SRC_FPU;
                end else begin
                    r = SRC_NONE;
                end
            end
        endcase
        return r;
    endfunction

    // One-hot decode of a source index; SRC_NONE decodes to no bits.
    function automatic logic [2:0] src_onehot(input logic [1:0] k);
        logic [2:0] r;
        case (k)
            SRC_MUL: r = 3'b001;
            SRC_DIV: r = 3'b010;
            SRC_FPU: r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Output register and round-robin pointer
    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [FLAG_W-1:0] flags_r;
    logic [1:0]        src_r;
    logic [1:0]        prio_r;

    // Combinational arbitration results
    logic [2:0]        req_s;
    logic [1:0]        prio_eff_s;
    logic [1:0]        win_s;
    logic [2:0]        grant_s;
    logic              load_s;
    logic [2:0]        ready_s;
    logic              accept_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;
    logic [FLAG_W-1:0] win_flags_s;

    // Pick the round-robin winner among the current requesters.
    always_comb begin
        req_s      = {valid_in_fpu, valid_in_div, valid_in_mul};
        prio_eff_s = norm_prio(prio_r);
        win_s      = rr_pick(req_s, prio_eff_s);
        grant_s    = src_onehot(win_s);
    end

    // Decide whether the output register can take a result and raise the
    // winner's ready; reset and flush suppress every grant.
    always_comb begin
        load_s = !flush && (!valid_r || ready_in);
        if (reset || !load_s) begin
            ready_s = 3'b000;
        end else begin
            ready_s = grant_s;
        end
        accept_s = |ready_s;
    end

    // Steer the winner's payload toward the output register; only the FPU
    // carries exception flags.
    always_comb begin
        win_addr_s  = {ADDR_W{1'b0}};
        win_data_s  = {DATA_W{1'b0}};
        win_flags_s = {FLAG_W{1'b0}};
        case (win_s)
            SRC_MUL: begin
                win_addr_s  = rd_addr_mul;
                win_data_s  = rd_data_mul;
                win_flags_s = {FLAG_W{1'b0}};
            end
            SRC_DIV: begin
                win_addr_s  = rd_addr_div;
                win_data_s  = rd_data_div;
                win_flags_s = {FLAG_W{1'b0}};
            end
            SRC_FPU: begin
                win_addr_s  = rd_addr_fpu;
                win_data_s  = rd_data_fpu;
                win_flags_s = flags_fpu;
            end
            default: begin
                win_addr_s  = {ADDR_W{1'b0}};
                win_data_s  = {DATA_W{1'b0}};
                win_flags_s = {FLAG_W{1'b0}};
            end
        endcase
    end

    // Output register and pointer update: reset, then flush, then capture
    // a new result, then drain to empty, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            flags_r <= {FLAG_W{1'b0}};
            src_r   <= 2'd0;
            prio_r  <= 2'd0;
        end else if (flush) begin
            valid_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            flags_r <= {FLAG_W{1'b0}};
            src_r   <= 2'd0;
            prio_r  <= prio_r;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            addr_r  <= win_addr_s;
            data_r  <= win_data_s;
            flags_r <= win_flags_s;
            src_r   <= win_s;
            prio_r  <= next_prio(win_s);
        end else if (valid_r && ready_in) begin
            valid_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            flags_r <= {FLAG_W{1'b0}};
            src_r   <= 2'd0;
            prio_r  <= prio_r;
        end else begin
            valid_r <= valid_r;
            addr_r  <= addr_r;
            data_r  <= data_r;
            flags_r <= flags_r;
            src_r   <= src_r;
            prio_r  <= prio_r;
        end
    end

    assign ready_out_mul = ready_s[0];
    assign ready_out_div = ready_s[1];
    assign ready_out_fpu = ready_s[2];

    assign valid_out   = valid_r;
    assign rd_addr_out = addr_r;
    assign rd_data_out = data_r;
    assign flags_out   = flags_r;
    assign src_out     = src_r;

endmodule

// File: tb/tb_result_arbiter.sv
// Testbench for result_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based reference model.

module tb_result_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int FLAG_W = 5;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              valid_in_mul, valid_in_div, valid_in_fpu;
    logic              ready_out_mul, ready_out_div, ready_out_fpu;
    logic [ADDR_W-1:0] rd_addr_mul, rd_addr_div, rd_addr_fpu;
    logic [DATA_W-1:0] rd_data_mul, rd_data_div, rd_data_fpu;
    logic [FLAG_W-1:0] flags_fpu;
    logic              valid_out;
    logic              ready_in;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [DATA_W-1:0] rd_data_out;
    logic [FLAG_W-1:0] flags_out;
    logic [1:0]        src_out;

    result_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .valid_in_mul  (valid_in_mul),
        .valid_in_div  (valid_in_div),
        .valid_in_fpu  (valid_in_fpu),
        .ready_out_mul (ready_out_mul),
        .ready_out_div (ready_out_div),
        .ready_out_fpu (ready_out_fpu),
        .rd_addr_mul   (rd_addr_mul),
        .rd_addr_div   (rd_addr_div),
        .rd_addr_fpu   (rd_addr_fpu),
        .rd_data_mul   (rd_data_mul),
        .rd_data_div   (rd_data_div),
        .rd_data_fpu   (rd_data_fpu),
        .flags_fpu     (flags_fpu),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .rd_addr_out   (rd_addr_out),
        .rd_data_out   (rd_data_out),
        .flags_out     (flags_out),
        .src_out       (src_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] flags;
        logic [1:0]        src;
    } res_t;

    // Results the output register is expected to hold, oldest first.
    res_t exp_q[$];
    res_t pend;
    bit   pend_valid = 1'b0;
    bit   clr_pend   = 1'b0;
    bit   mon_en     = 1'b0;
    int   prio_m     = 0;

    // Payload offered by each unit for the next step (index 0=MUL,1=DIV,2=FPU).
    logic [ADDR_W-1:0] a_v [3];
    logic [DATA_W-1:0] d_v [3];
    logic [FLAG_W-1:0] f_v;

    int nvec  = 0;
    int nfail = 0;

    task automatic rand_payload();
        for (int i = 0; i < 3; i++) begin
            a_v[i] = ADDR_W'($urandom);
            d_v[i] = $urandom;
        end
        f_v = FLAG_W'($urandom);
    endtask

    // Apply one cycle of stimulus, update the reference model and check
    // the combinational ready outputs.
    task automatic step(input logic [2:0] v, input logic rdy, input logic fl, input logic rst);
        int         k;
        logic       load;
        logic [2:0] exp_ready;
        @(posedge clk);
        #1;
        if (clr_pend) begin
            exp_q.delete();
            mon_en   = 1'b1;
            clr_pend = 1'b0;
        end
        if (pend_valid) begin
            exp_q.push_back(pend);
            pend_valid = 1'b0;
        end
        valid_in_mul = v[0];
        valid_in_div = v[1];
        valid_in_fpu = v[2];
        ready_in     = rdy;
        flush        = fl;
        reset        = rst;
        rd_addr_mul  = a_v[0];
        rd_addr_div  = a_v[1];
        rd_addr_fpu  = a_v[2];
        rd_data_mul  = d_v[0];
        rd_data_div  = d_v[1];
        rd_data_fpu  = d_v[2];
        flags_fpu    = f_v;

        load      = !fl && !rst && (exp_q.size() == 0 || rdy);
        k         = -1;
        exp_ready = 3'b000;
        if (load) begin
            for (int i = 0; i < 3; i++) begin
                int c;
                c = (prio_m + i) % 3;
                if (k < 0 && v[c]) k = c;
            end
        end
        if (k >= 0) begin
            exp_ready[k] = 1'b1;
            pend.src     = 2'(k);
            pend.addr    = a_v[k];
            pend.data    = d_v[k];
            pend.flags   = (k == 2) ? f_v : {FLAG_W{1'b0}};
            pend_valid   = 1'b1;
            prio_m       = (k + 1) % 3;
        end
        if (rst) begin
            prio_m   = 0;
            clr_pend = 1'b1;
        end

        #1;
        nvec++;
        if ({ready_out_fpu, ready_out_div, ready_out_mul} !== exp_ready) begin
            nfail++;
            $display("FAIL ready_out t=%0t: got fpu/div/mul=%b required %b (v=%b rdy=%b fl=%b rst=%b)",
                     $time, {ready_out_fpu, ready_out_div, ready_out_mul}, exp_ready, v, rdy, fl, rst);
        end
    endtask

    // Monitor: compare the output register against the model each cycle
    // and retire the expected entry when it is drained or flushed.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                nvec++;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    if (valid_out !== 1'b1 || rd_addr_out !== e.addr || rd_data_out !== e.data ||
                        flags_out !== e.flags || src_out !== e.src) begin
                        nfail++;
                        $display("FAIL out_held t=%0t: got v=%b a=%h d=%h f=%h s=%0d required v=1 a=%h d=%h f=%h s=%0d",
                                 $time, valid_out, rd_addr_out, rd_data_out, flags_out, src_out,
                                 e.addr, e.data, e.flags, e.src);
                    end
                    if (ready_in || flush) void'(exp_q.pop_front());
                end else begin
                    if (valid_out !== 1'b0 || rd_addr_out !== '0 || rd_data_out !== '0 ||
                        flags_out !== '0 || src_out !== 2'd0) begin
                        nfail++;
                        $display("FAIL out_empty t=%0t: got v=%b a=%h d=%h f=%h s=%0d required all zero",
                                 $time, valid_out, rd_addr_out, rd_data_out, flags_out, src_out);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; ready_in = 1'b0;
        valid_in_mul = 1'b0; valid_in_div = 1'b0; valid_in_fpu = 1'b0;
        rd_addr_mul = '0; rd_addr_div = '0; rd_addr_fpu = '0;
        rd_data_mul = '0; rd_data_div = '0; rd_data_fpu = '0; flags_fpu = '0;
        rand_payload();

        // Reset with every unit requesting: no ready may rise.
        repeat (3) step(3'b111, 1'b1, 1'b0, 1'b1);

        // Round-robin with all three units requesting continuously.
        d_v[0] = 32'h0000_0011; d_v[1] = 32'h0000_0022; d_v[2] = 32'h0000_0033;
        a_v[0] = 6'h01; a_v[1] = 6'h02; a_v[2] = 6'h23; f_v = 5'b10100;
        repeat (4) step(3'b111, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);

        // Backpressure: FPU result held while MUL waits.
        a_v[2] = 6'h25; d_v[2] = 32'h3F80_0000; f_v = 5'b00001;
        step(3'b100, 1'b1, 1'b0, 1'b0);
        a_v[0] = 6'h07; d_v[0] = 32'hDEAD_BEEF;
        repeat (4) step(3'b001, 1'b0, 1'b0, 1'b0);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);

        // Single requester: DIV wins three times in a row, then drains.
        rand_payload();
        repeat (3) step(3'b010, 1'b1, 1'b0, 1'b0);
        repeat (2) step(3'b000, 1'b1, 1'b0, 1'b0);

        // Flush while a DIV result is held and FPU requests.
        step(3'b010, 1'b1, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b1, 1'b0);
        step(3'b100, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);

        // Drain without refill of a single MUL result.
        rand_payload();
        step(3'b001, 1'b1, 1'b0, 1'b0);
        repeat (2) step(3'b000, 1'b1, 1'b0, 1'b0);

        // Random traffic with backpressure, flushes and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            rand_payload();
            step(3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        repeat (2) step(3'b000, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/result_arbiter.md
# result_arbiter

Shares the single MEM-stage writeback path among the three long-latency execution units (MUL, DIV, FPU) that the decode stage dispatches to through per-unit valid/ready handshakes. Each unit offers one completed result at a time. The arbiter grants one per cycle in round-robin order and holds the winner in a one-entry output register. That register drives the `rd_wena_MEM` / `rd_addr_MEM` / `rd_data_MEM` path back to the register file.

## Interface
Parameters:
- `DATA_W`, 32, result data width
- `ADDR_W`, 6, destination register address width (bit 5 selects the FP register bank)
- `FLAG_W`, 5, exception-flag width (FPU fflags; MUL/DIV drive zero)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  pipeline flush; drops the held result
- `valid_in_mul` / `valid_in_div` / `valid_in_fpu`  in  1  each  unit offers a result
- `ready_out_mul` / `ready_out_div` / `ready_out_fpu`  out  1  each  result accepted this cycle
- `rd_addr_mul` / `rd_addr_div` / `rd_addr_fpu`  in  ADDR_W each  destination register
- `rd_data_mul` / `rd_data_div` / `rd_data_fpu`  in  DATA_W each  result value
- `flags_fpu`  in  FLAG_W  FPU exception flags
- `valid_out`  out  1  output register holds a result
- `ready_in`  in  1  downstream (MEM/WB) accepts the result
- `rd_addr_out`  out  ADDR_W  held destination
- `rd_data_out`  out  DATA_W  held value
- `flags_out`  out  FLAG_W  held flags (zero unless the source is FPU)
- `src_out`  out  2  held source: 0 = MUL, 1 = DIV, 2 = FPU

## Operation
- **Load condition:** `load = !flush && (!valid_out || ready_in)`. The output register can take a new result when it is empty or being drained this cycle.
- **Round-robin pointer:** `prio` is 2 bits, values 0..2, and holds the highest-priority source.
  - The grant goes to the first asserted `valid_in_*` scanning `prio`, `prio+1`, `prio+2`, all mod 3.
  - Value 3 is unreachable. If it occurs, treat it as 0.
- **Ready generation:**
  - `ready_out_x = load && grant_x`. At most one `ready_out_*` is high per cycle.
  - `ready_out_*` depends combinationally on `valid_in_*`. Requesters must not make `valid_in_*` depend on `ready_out_*`.
- **On accept of source k** (`valid_in_k && ready_out_k`), at the clock edge:
  - the output register captures `rd_addr_k`, `rd_data_k`, the flags (`flags_fpu` for FPU, else 0), and `src_out = k`;
  - `valid_out` goes to 1;
  - `prio` becomes (k+1) mod 3.
- **Drain without refill:** if `valid_out && ready_in` and nothing is granted, `valid_out` goes to 0 and the data fields clear to 0.
- **Hold:** if `valid_out && !ready_in`, all output fields hold and all `ready_out_*` are low.
- **Flush:**
  - `valid_out` and all data fields go to 0 and no grant is issued that cycle;
  - `prio` is unchanged;
  - requesters discard their own state on flush, not this block.
- **Reset:**
  - `valid_out` = 0, `rd_addr_out` = 0, `rd_data_out` = 0, `flags_out` = 0, `src_out` = 0, `prio` = 0;
  - all `ready_out_*` = 0 while `reset` is high;
  - reset has priority over flush and over any handshake, and aborts a held result with no writeback.

## Timing
- Latency is 1 cycle: a result accepted at edge N is visible on `valid_out` / `rd_*_out` after edge N.
- Throughput is 1 result per cycle with `ready_in` held high. Back-to-back drain and refill happen in the same cycle with no bubble.
- Fairness: a continuously asserted requester is granted within 3 loads.
- Outputs are purely registered. `ready_out_*` is the only combinational output.
- Simultaneous flush and an asserted `valid_in_*`: no accept, and the requester keeps its result.

## Test plan
- **Reset:** assert `reset` with all three valids high -> all `ready_out_*` = 0, `valid_out` = 0, `src_out` = 0. First cycle after release: `ready_out_mul` = 1.
- **Round-robin:** all three valid continuously, `ready_in` = 1, data MUL = 0x11, DIV = 0x22, FPU = 0x33 -> `rd_data_out` sequence 0x11, 0x22, 0x33, 0x11 on consecutive cycles, `src_out` 0, 1, 2, 0.
- **Backpressure:** result held (FPU, addr 6'h25, data 0x3F800000, flags 5'b00001), `ready_in` = 0 for 4 cycles, MUL valid -> outputs stable, `ready_out_mul` = 0 throughout. `ready_in` = 1 -> MUL accepted the same cycle, `src_out` = 0 next cycle.
- **Single requester:** only DIV valid for 3 results, `ready_in` = 1 -> three accepts on consecutive cycles; `prio` = 2 after each, DIV still granted.
- **Flush mid-hold:** `valid_out` = 1 (DIV), `flush` = 1 with FPU valid -> next cycle `valid_out` = 0, `ready_out_fpu` = 0 during flush, `prio` unchanged; FPU is granted the cycle after the flush drops.
- **Drain without refill:** one MUL result, `ready_in` = 1, no other valids -> `valid_out` 1 for exactly one cycle, then 0 with `rd_data_out` = 0.
